reg_bus_load_operand: RTL and testbench
=======================================

Name: reg_bus_load_operand

Overview:
- Operand register (B/C style) that captures a value *from* the data bus and presents it continuously to the ALU as an operand.
- Capture is gated by a relay-settle model: the bus must hold stable for SETTLE_CYCLES clocks before it is latched.
- Can also drive its stored content back onto the data bus when selected.
- Sits between the data bus and the ALU operand inputs in the register unit.

Parameters:
- N, 8, data/register width in bits.
- SETTLE_CYCLES, 3, consecutive stable-bus cycles required before capture; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- databus_in  input  N  data bus value seen by this register.
- load  input  1  level request to load from the bus; held until capture, then released.
- sel  input  1  request to drive content onto the data bus.
- alu_operand  output  N  current register content, fed to the ALU.
- databus_out  output  N  content when databus_oe=1, else all zeros.
- databus_oe  output  1  bus drive enable.
- busy  output  1  high in SETTLE or CAPTURE.
- load_done  output  1  one-cycle pulse, high in CAPTURE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, content=0, shadow=0, cnt=0.
  - All outputs 0.
  - Reset mid-SETTLE discards the pending load; content returns to 0.
- State IDLE:
  - load=1 sampled → SETTLE; shadow<=databus_in, cnt<=1.
  - load=0 → stay in IDLE.
- State SETTLE:
  - load=0 → abort to IDLE; content unchanged; no load_done.
  - databus_in!=shadow → shadow<=databus_in, cnt<=1; stay in SETTLE (glitch restart).
  - databus_in==shadow and cnt<SETTLE_CYCLES-1 → cnt<=cnt+1.
  - databus_in==shadow and cnt==SETTLE_CYCLES-1 → content<=shadow, go to CAPTURE.
- State CAPTURE:
  - Lasts exactly one cycle; load_done=1.
  - Next state is RELEASE if load=1, else IDLE.
- State RELEASE:
  - Waits for load=0, then → IDLE.
  - A held load never causes a second capture; re-arming requires load to drop for at least one sampled cycle.
- Latency (stable bus):
  - load sampled at edge 0 → content/alu_operand update after edge SETTLE_CYCLES-1.
  - load_done high during the following cycle.
- alu_operand:
  - Always equals content (registered).
  - Unchanged except on the SETTLE→CAPTURE edge or at reset.
- Bus drive:
  - databus_oe = sel & ~load & (state==IDLE), combinational.
  - load has priority over sel, so the register never snapshots its own output.
  - sel is ignored while busy or in RELEASE.
- busy = (state==SETTLE)|(state==CAPTURE).
- Counter width: ceil(log2(SETTLE_CYCLES+1)); no wrap is possible given the restart rule.

Optional Feature:
- Macro: BUS_GLITCH_COUNT_EN.
- Defined:
  - Adds output glitch_count (8 bits).
  - Increments by 1 on each SETTLE-state cycle where databus_in!=shadow.
  - Saturates at 255.
  - Cleared by reset only; readable at all times; does not affect FSM behaviour.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, N=8, SETTLE_CYCLES=3:
  - Stimulus: databus_in=0x5A, load=1 for 5 cycles, then 0.
  - Response: alu_operand=0x5A after the 3rd edge from the load sample; load_done high exactly 1 cycle.
  - Response: no second capture while load is held; state returns to IDLE after load falls.
- Glitch restart:
  - Stimulus: load=1; bus=0x11 for 2 cycles, then 0x22 held.
  - Response: capture of 0x22 occurs 3 stable cycles after the change; 0x11 is never latched.
  - With BUS_GLITCH_COUNT_EN: glitch_count=1.
- Abort:
  - Stimulus: content=0x33; load=1 with bus=0x44, dropped after 1 cycle in SETTLE.
  - Response: alu_operand stays 0x33; load_done never asserts; busy falls.
- Bus drive priority:
  - Stimulus: content=0xA5, IDLE, sel=1.
  - Response: databus_oe=1, databus_out=0xA5.
  - Stimulus: sel=1 and load=1 together.
  - Response: databus_oe=0 that cycle and throughout SETTLE/CAPTURE/RELEASE.
- Async reset mid-SETTLE:
  - Stimulus: rst_n=0 asserted between edges during SETTLE.
  - Response: immediately alu_operand=0, busy=0, databus_oe=0.
  - Response: after release, a fresh load of 0xFF captures normally.

Source files
------------

// File: rtl/reg_bus_load_operand.sv
// Bus-loaded ALU operand register with a relay-settle capture gate and optional bus drive-back.
// Optional feature: define BUS_GLITCH_COUNT_EN to add the saturating glitch_count output.
module reg_bus_load_operand #(
    parameter int N             = 8,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] databus_in,
    input  logic         load,
    input  logic         sel,
    output logic [N-1:0] alu_operand,
    output logic [N-1:0] databus_out,
    output logic         databus_oe,
    output logic         busy,
    output logic         load_done
`ifdef BUS_GLITCH_COUNT_EN
    ,
    output logic [7:0]   glitch_count
`endif
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  content, content_n;
    logic [N-1:0]  shadow, shadow_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          bus_changed;

    assign bus_changed = (databus_in != shadow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            content <= '0;
            shadow  <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            content <= content_n;
            shadow  <= shadow_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        content_n = content;
        shadow_n  = shadow;
        cnt_n     = cnt;
        case (state)
            IDLE: begin
                if (load) begin
                    state_n  = SETTLE;
                    shadow_n = databus_in;
                    cnt_n    = CW'(1);
                end
            end
            SETTLE: begin
                // A dropped load abandons the capture; a bus change restarts the settle window.
                if (!load) begin
                    state_n = IDLE;
                end else if (bus_changed) begin
                    shadow_n = databus_in;
                    cnt_n    = CW'(1);
                end else if (cnt == CNT_LAST) begin
                    content_n = shadow;
                    state_n   = CAPTURE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            CAPTURE: begin
                state_n = load ? RELEASE : IDLE;
            end
            RELEASE: begin
                if (!load) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // load outranks sel so the register never latches its own driven value.
    assign databus_oe  = rst_n & sel & ~load & (state == IDLE);
    assign databus_out = databus_oe ? content : '0;
    assign alu_operand = content;
    assign busy        = (state == SETTLE) || (state == CAPTURE);
    assign load_done   = (state == CAPTURE);

`ifdef BUS_GLITCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_count <= '0;
        end else if ((state == SETTLE) && bus_changed && (glitch_count != 8'hFF)) begin
            glitch_count <= glitch_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_bus_load_operand.sv
// Self-checking bench for reg_bus_load_operand: capture latency, glitch restart, abort,
// bus-drive priority, async reset and back-to-back loads against an expected-capture queue.
module tb_reg_bus_load_operand;

    localparam int N  = 8;
    localparam int SC = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] databus_in;
    logic         load;
    logic         sel;
    logic [N-1:0] alu_operand;
    logic [N-1:0] databus_out;
    logic         databus_oe;
    logic         busy;
    logic         load_done;
`ifdef BUS_GLITCH_COUNT_EN
    logic [7:0]   glitch_count;
`endif

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    logic [N-1:0] exp_q[$];

    reg_bus_load_operand #(.N(N), .SETTLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .databus_in  (databus_in),
        .load        (load),
        .sel         (sel),
        .alu_operand (alu_operand),
        .databus_out (databus_out),
        .databus_oe  (databus_oe),
        .busy        (busy),
        .load_done   (load_done)
`ifdef BUS_GLITCH_COUNT_EN
        ,
        .glitch_count(glitch_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // scoreboard: every load_done cycle must match the oldest expected capture
    always @(negedge clk) begin
        if (rst_n && load_done) begin
            done_pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL capture_unexpected: alu_operand=%02h, no capture expected", alu_operand);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (alu_operand !== e) begin
                    errors++;
                    $display("FAIL capture_value: got %02h expected %02h", alu_operand, e);
                end
            end
        end
    end

    // driver: stable-bus load, with latency and final-content checks
    task automatic do_load(input logic [N-1:0] v);
        int n;
        bit seen;
        databus_in = v;
        load = 1'b1;
        exp_q.push_back(v);
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (load_done) seen = 1;
        end
        checks++;
        if (!seen || n != SC) begin
            errors++;
            $display("FAIL load_latency: value %02h done after %0d edges (seen=%0d) expected %0d", v, n, seen, SC);
        end
        load = 1'b0;
        tick();
        checks++;
        if (alu_operand !== v || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_result: alu=%02h busy=%0b expected alu=%02h busy=0", alu_operand, busy, v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load = 1'b0;
        sel = 1'b1;
        databus_in = 8'hC3;
        #13;
        checks++;
        if (alu_operand !== 8'h00 || databus_out !== 8'h00 || databus_oe !== 1'b0 ||
            busy !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: alu=%02h out=%02h oe=%0b busy=%0b done=%0b expected all 0",
                     alu_operand, databus_out, databus_oe, busy, load_done);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_load();
        logic [N-1:0] exp_alu [5];
        logic         exp_busy[5];
        logic         exp_done[5];
        int pulses0;
        exp_alu  = '{8'h00, 8'h00, 8'h5A, 8'h5A, 8'h5A};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        pulses0 = done_pulses;
        databus_in = 8'h5A;
        load = 1'b1;
        exp_q.push_back(8'h5A);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (alu_operand !== exp_alu[i] || busy !== exp_busy[i] || load_done !== exp_done[i]) begin
                errors++;
                $display("FAIL basic_edge%0d: alu=%02h busy=%0b done=%0b expected alu=%02h busy=%0b done=%0b",
                         i, alu_operand, busy, load_done, exp_alu[i], exp_busy[i], exp_done[i]);
            end
        end
        load = 1'b0;
        sel = 1'b1;
        #1;
        checks++;
        if (databus_oe !== 1'b0) begin
            errors++;
            $display("FAIL release_sel_ignored: oe=%0b expected 0", databus_oe);
        end
        tick();
        checks++;
        if (databus_oe !== 1'b1 || databus_out !== 8'h5A || done_pulses - pulses0 != 1) begin
            errors++;
            $display("FAIL basic_idle: oe=%0b out=%02h pulses=%0d expected oe=1 out=5a pulses=1",
                     databus_oe, databus_out, done_pulses - pulses0);
        end
        sel = 1'b0;
    endtask

    task automatic test_glitch_restart();
        logic [N-1:0] bus_seq[5];
        logic [N-1:0] exp_alu[5];
        logic         exp_done[5];
        bus_seq  = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h22};
        exp_alu  = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h22};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        load = 1'b1;
        exp_q.push_back(8'h22);
        for (int i = 0; i < 5; i++) begin
            databus_in = bus_seq[i];
            tick();
            checks++;
            if (alu_operand !== exp_alu[i] || load_done !== exp_done[i]) begin
                errors++;
                $display("FAIL glitch_edge%0d: alu=%02h done=%0b expected alu=%02h done=%0b",
                         i, alu_operand, load_done, exp_alu[i], exp_done[i]);
            end
        end
        load = 1'b0;
        tick();
`ifdef BUS_GLITCH_COUNT_EN
        checks++;
        if (glitch_count !== 8'd1) begin
            errors++;
            $display("FAIL glitch_count: got %0d expected 1", glitch_count);
        end
`endif
    endtask

    task automatic test_abort();
        int pulses0;
        do_load(8'h33);
        pulses0 = done_pulses;
        databus_in = 8'h44;
        load = 1'b1;
        tick();
        tick();
        load = 1'b0;
        tick();
        tick();
        checks++;
        if (alu_operand !== 8'h33 || busy !== 1'b0 || done_pulses != pulses0) begin
            errors++;
            $display("FAIL abort: alu=%02h busy=%0b pulses=%0d expected alu=33 busy=0 pulses=0",
                     alu_operand, busy, done_pulses - pulses0);
        end
    endtask

    task automatic test_bus_drive();
        do_load(8'hA5);
        sel = 1'b1;
        #1;
        checks++;
        if (databus_oe !== 1'b1 || databus_out !== 8'hA5) begin
            errors++;
            $display("FAIL drive_idle: oe=%0b out=%02h expected oe=1 out=a5", databus_oe, databus_out);
        end
        databus_in = 8'h3C;
        load = 1'b1;
        exp_q.push_back(8'h3C);
        #1;
        checks++;
        if (databus_oe !== 1'b0 || databus_out !== 8'h00) begin
            errors++;
            $display("FAIL drive_load_priority: oe=%0b out=%02h expected oe=0 out=00", databus_oe, databus_out);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (databus_oe !== 1'b0) begin
                errors++;
                $display("FAIL drive_busy_edge%0d: oe=%0b expected 0", i, databus_oe);
            end
        end
        load = 1'b0;
        tick();
        checks++;
        if (databus_oe !== 1'b1 || databus_out !== 8'h3C) begin
            errors++;
            $display("FAIL drive_after: oe=%0b out=%02h expected oe=1 out=3c", databus_oe, databus_out);
        end
        sel = 1'b0;
    endtask

    task automatic test_async_reset();
        databus_in = 8'h77;
        load = 1'b1;
        sel = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_operand !== 8'h00 || busy !== 1'b0 || databus_oe !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: alu=%02h busy=%0b oe=%0b expected 00/0/0", alu_operand, busy, databus_oe);
        end
        load = 1'b0;
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_load(8'hFF);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_load(N'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_glitch_restart();
        test_abort();
        test_bus_drive();
        test_async_reset();
        test_back_to_back();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d captures outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
